// File: rtl/mm_pkg.sv
// Shared definitions for the matrix multiply scheduler: word width, FSM
// state encoding and the index-width helper.
package mm_pkg;

  localparam int WORD_WIDTH = 32;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    ISSUE       = 3'd1,
    WAIT_RESULT = 3'd2,
    STORE       = 3'd3,
    DONE        = 3'd4
  } sched_state_t;

  // Width of a row/column index; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/matrix_vector_select.sv
// Combinational extraction of one row (COLUMN_MODE=0) or one column
// (COLUMN_MODE=1) from a row-major packed N x N matrix of words.
module matrix_vector_select
  import mm_pkg::*;
#(
  parameter int N           = 4,
  parameter bit COLUMN_MODE = 1'b0,
  localparam int IW         = idx_width(N)
) (
  input  logic [WORD_WIDTH*N*N-1:0] matrix,
  input  logic [IW-1:0]             index,
  output logic [WORD_WIDTH*N-1:0]   vector
);

  // Index compare against constants keeps every slice static: a plain mux.
  always_comb begin
    vector = '0;
    for (int r = 0; r < N; r++) begin
      if (index == IW'(r)) begin
        for (int k = 0; k < N; k++) begin
          if (COLUMN_MODE)
            vector[k*WORD_WIDTH +: WORD_WIDTH] = matrix[(k*N + r)*WORD_WIDTH +: WORD_WIDTH];
          else
            vector[k*WORD_WIDTH +: WORD_WIDTH] = matrix[(r*N + k)*WORD_WIDTH +: WORD_WIDTH];
        end
      end
    end
  end

endmodule

// File: rtl/matrix_mult_scheduler.sv
// Walks all N x N output positions of C = A*B in row-major order, feeding one
// shared inner_product unit through its stb/ack handshakes and collecting results.
module matrix_mult_scheduler
  import mm_pkg::*;
#(
  parameter int N    = 4,
  localparam int IW  = idx_width(N)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [WORD_WIDTH*N*N-1:0] a_matrix,
  input  logic [WORD_WIDTH*N*N-1:0] b_matrix,
  output logic [WORD_WIDTH*N-1:0]   ip_row,
  output logic [WORD_WIDTH*N-1:0]   ip_column,
  output logic                      ip_in_stb,
  input  logic                      ip_in_ack,
  input  logic [WORD_WIDTH-1:0]     ip_out,
  input  logic                      ip_out_stb,
  output logic                      ip_out_ack,
  output logic [WORD_WIDTH*N*N-1:0] c_matrix,
  output logic [IW-1:0]             cur_row,
  output logic [IW-1:0]             cur_col,
  output logic                      busy,
  output logic                      done
);

  sched_state_t    state;
  sched_state_t    state_next;
  logic [IW-1:0]   i;
  logic [IW-1:0]   j;
  logic            last_col;
  logic            last_row;
  logic            result_take;

  assign last_col    = (j == IW'(N-1));
  assign last_row    = (i == IW'(N-1));
  assign result_take = (state == WAIT_RESULT) && ip_out_stb && ip_out_ack;
  assign cur_row     = i;
  assign cur_col     = j;

  matrix_vector_select #(.N(N), .COLUMN_MODE(1'b0)) u_row_select (
    .matrix (a_matrix),
    .index  (i),
    .vector (ip_row)
  );

  matrix_vector_select #(.N(N), .COLUMN_MODE(1'b1)) u_col_select (
    .matrix (b_matrix),
    .index  (j),
    .vector (ip_column)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:        if (start)       state_next = ISSUE;
      ISSUE:       if (ip_in_ack)   state_next = WAIT_RESULT;
      WAIT_RESULT: if (result_take) state_next = STORE;
      STORE:       state_next = (last_row && last_col) ? DONE : ISSUE;
      DONE:        state_next = IDLE;
      default:     state_next = IDLE;
    endcase
  end

  always_comb begin
    ip_in_stb  = (state == ISSUE);
    ip_out_ack = (state == WAIT_RESULT);
    busy       = (state != IDLE);
    done       = (state == DONE);
  end

  // Indices stay at (N-1,N-1) after the last element until the next start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i <= '0;
      j <= '0;
    end else if (state == IDLE && start) begin
      i <= '0;
      j <= '0;
    end else if (state == STORE) begin
      if (!last_col) begin
        j <= j + 1'b1;
      end else if (!last_row) begin
        j <= '0;
        i <= i + 1'b1;
      end
    end
  end

  // Only the addressed element is written; no bulk clear outside reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_matrix <= '0;
    end else if (result_take) begin
      for (int r = 0; r < N; r++) begin
        for (int col = 0; col < N; col++) begin
          if (i == IW'(r) && j == IW'(col))
            c_matrix[(r*N + col)*WORD_WIDTH +: WORD_WIDTH] <= ip_out;
        end
      end
    end
  end

endmodule

// File: tb/tb_matrix_mult_scheduler.sv
// Scoreboard bench: expected C elements are queued when a job starts and
// popped as each result handshake completes; a behavioural unit answers.
module tb_matrix_mult_scheduler;
  import mm_pkg::*;

  localparam int N  = 2;
  localparam int W  = WORD_WIDTH;
  localparam int IW = idx_width(N);
  localparam logic [W-1:0] ONE  = 32'h3F800000;
  localparam logic [W-1:0] JUNK = 32'hDEADBEEF;

  typedef struct {
    int           i;
    int           j;
    logic [W-1:0] val;
  } sb_entry_t;

  logic              clk;
  logic              rst;
  logic              start;
  logic [W*N*N-1:0]  a_matrix;
  logic [W*N*N-1:0]  b_matrix;
  logic [W*N-1:0]    ip_row;
  logic [W*N-1:0]    ip_column;
  logic              ip_in_stb;
  logic              ip_in_ack;
  logic [W-1:0]      ip_out;
  logic              ip_out_stb;
  logic              ip_out_ack;
  logic [W*N*N-1:0]  c_matrix;
  logic [IW-1:0]     cur_row;
  logic [IW-1:0]     cur_col;
  logic              busy;
  logic              done;

  int                ack_delay;
  int                ack_cnt;
  logic              spurious;
  logic              pending;
  logic [W-1:0]      pend_val;

  sb_entry_t         sb[$];
  int                checks = 0;
  int                passes = 0;

  matrix_mult_scheduler #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a_matrix   (a_matrix),
    .b_matrix   (b_matrix),
    .ip_row     (ip_row),
    .ip_column  (ip_column),
    .ip_in_stb  (ip_in_stb),
    .ip_in_ack  (ip_in_ack),
    .ip_out     (ip_out),
    .ip_out_stb (ip_out_stb),
    .ip_out_ack (ip_out_ack),
    .c_matrix   (c_matrix),
    .cur_row    (cur_row),
    .cur_col    (cur_col),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W*N*N-1:0] pack2(input logic [W-1:0] e00, input logic [W-1:0] e01,
                                             input logic [W-1:0] e10, input logic [W-1:0] e11);
    return {e11, e10, e01, e00};
  endfunction

  function automatic logic [W-1:0] elem(input logic [W*N*N-1:0] m, input int r, input int c);
    return m[W*(r*N + c) +: W];
  endfunction

  function automatic logic [W*N-1:0] exp_row(input int r);
    logic [W*N-1:0] v;
    for (int k = 0; k < N; k++) v[W*k +: W] = elem(a_matrix, r, k);
    return v;
  endfunction

  function automatic logic [W*N-1:0] exp_col(input int c);
    logic [W*N-1:0] v;
    for (int k = 0; k < N; k++) v[W*k +: W] = elem(b_matrix, k, c);
    return v;
  endfunction

  // B holds only 0.0/1.0 with one 1.0 per column, so the dot product is a pick.
  function automatic logic [W-1:0] exp_c(input int r, input int c);
    logic [W-1:0] v;
    v = '0;
    for (int k = 0; k < N; k++)
      if (elem(b_matrix, k, c) == ONE) v = v | elem(a_matrix, r, k);
    return v;
  endfunction

  function automatic logic [W-1:0] unit_result(input logic [W*N-1:0] row, input logic [W*N-1:0] col);
    logic [W-1:0] v;
    v = '0;
    for (int k = 0; k < N; k++)
      if (col[W*k +: W] == ONE) v = v | row[W*k +: W];
    return v;
  endfunction

  // Behavioural inner_product unit with a programmable operand-ack delay.
  assign ip_in_ack  = ip_in_stb && (ack_cnt >= ack_delay);
  assign ip_out_stb = pending || spurious;
  assign ip_out     = pending ? pend_val : JUNK;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_cnt  <= 0;
      pending  <= 1'b0;
      pend_val <= '0;
    end else begin
      if (ip_in_stb && !ip_in_ack) ack_cnt <= ack_cnt + 1;
      else                         ack_cnt <= 0;
      if (ip_in_stb && ip_in_ack) begin
        pending  <= 1'b1;
        pend_val <= unit_result(ip_row, ip_column);
      end else if (ip_out_stb && ip_out_ack) begin
        pending  <= 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic push_job();
    sb_entry_t e;
    sb.delete();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        e.i = r; e.j = c; e.val = exp_c(r, c);
        sb.push_back(e);
      end
  endtask

  // Must be entered right at a falling edge; start is sampled on the next rise.
  task automatic run_job(input int exp_done_cycle, input int restart_at, input int spurious_at,
                         output int first_stb_len);
    int               cyc;
    int               done_cnt;
    int               done_cyc;
    logic             hs_prev;
    logic [W*N*N-1:0] c_before;
    sb_entry_t        e;
    cyc = 0; done_cnt = 0; done_cyc = -1; hs_prev = 1'b0; first_stb_len = 0;
    c_before = c_matrix;
    push_job();
    start = 1'b1;
    while (cyc < 600 && !(done_cyc >= 0 && cyc > done_cyc)) begin
      @(negedge clk);
      cyc++;
      start    = (restart_at > 0 && cyc == restart_at);
      spurious = (spurious_at > 0 && cyc == spurious_at);
      if (hs_prev) begin
        if (sb.size() == 0) begin
          checks++;
          $display("[TB] FAIL unexpected_result: got result handshake at cycle %0d, required none", cyc);
        end else begin
          e = sb.pop_front();
          checks++;
          if (elem(c_matrix, e.i, e.j) !== e.val)
            $display("[TB] FAIL c_elem(%0d,%0d): got %h required %h", e.i, e.j, elem(c_matrix, e.i, e.j), e.val);
          else passes++;
          checks++;
          if (cur_row !== IW'(e.i) || cur_col !== IW'(e.j))
            $display("[TB] FAIL store_index: got (%0d,%0d) required (%0d,%0d)", cur_row, cur_col, e.i, e.j);
          else passes++;
        end
      end
      if (cyc == 2) begin
        checks++;
        if (c_matrix !== c_before)
          $display("[TB] FAIL no_bulk_clear: got %h required %h", c_matrix, c_before);
        else passes++;
      end
      if (spurious_at > 0 && cyc == spurious_at + 1) begin
        checks++;
        if (elem(c_matrix, 0, 0) !== elem(c_before, 0, 0))
          $display("[TB] FAIL spurious_ignored: got %h required %h", elem(c_matrix, 0, 0), elem(c_before, 0, 0));
        else passes++;
      end
      if (ip_in_stb && sb.size() > 0) begin
        checks++;
        if (ip_row !== exp_row(sb[0].i))
          $display("[TB] FAIL ip_row(%0d): got %h required %h", sb[0].i, ip_row, exp_row(sb[0].i));
        else passes++;
        checks++;
        if (ip_column !== exp_col(sb[0].j))
          $display("[TB] FAIL ip_column(%0d): got %h required %h", sb[0].j, ip_column, exp_col(sb[0].j));
        else passes++;
        if (sb.size() == N*N) first_stb_len++;
      end
      hs_prev = ip_out_stb && ip_out_ack;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          if (restart_at > 0) start = 1'b1;
        end
      end
    end
    start = 1'b0;
    spurious = 1'b0;
    checks++;
    if (done_cyc < 0) $display("[TB] FAIL done_timeout: got no done in %0d cycles, required one", cyc);
    else passes++;
    checks++;
    if (done_cnt !== 1) $display("[TB] FAIL done_pulses: got %0d required 1", done_cnt);
    else passes++;
    if (exp_done_cycle > 0) begin
      checks++;
      if (done_cyc !== exp_done_cycle)
        $display("[TB] FAIL done_latency: got %0d required %0d", done_cyc, exp_done_cycle);
      else passes++;
    end
    checks++;
    if (sb.size() !== 0) $display("[TB] FAIL scoreboard_left: got %0d entries required 0", sb.size());
    else passes++;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("[TB] FAIL idle_after_done: got busy=%b done=%b required 0/0", busy, done);
    else passes++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || ip_in_stb !== 1'b0 || ip_out_ack !== 1'b0)
      $display("[TB] FAIL reset_ctrl: got busy=%b done=%b stb=%b ack=%b required all 0", busy, done, ip_in_stb, ip_out_ack);
    else passes++;
    checks++;
    if (c_matrix !== '0 || cur_row !== '0 || cur_col !== '0)
      $display("[TB] FAIL reset_data: got c=%h row=%0d col=%0d required 0", c_matrix, cur_row, cur_col);
    else passes++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_identity();
    int len;
    a_matrix = pack2(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000);
    b_matrix = pack2(ONE, '0, '0, ONE);
    run_job(3*N*N + 1, 0, 0, len);
    checks++;
    if (c_matrix !== a_matrix) $display("[TB] FAIL identity_c: got %h required %h", c_matrix, a_matrix);
    else passes++;
  endtask

  task automatic test_select();
    int len;
    b_matrix = pack2('0, ONE, ONE, '0);
    run_job(3*N*N + 1, 0, 0, len);
  endtask

  task automatic test_ack_delay();
    int len;
    a_matrix  = pack2(32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000);
    b_matrix  = pack2(ONE, '0, '0, ONE);
    ack_delay = 5;
    run_job(-1, 0, 0, len);
    ack_delay = 0;
    checks++;
    if (len !== 6) $display("[TB] FAIL stb_hold_cycles: got %0d required 6", len);
    else passes++;
  endtask

  task automatic test_spurious_out_stb();
    int len;
    a_matrix  = pack2(32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000);
    b_matrix  = pack2('0, ONE, ONE, '0);
    ack_delay = 3;
    run_job(-1, 0, 2, len);
    ack_delay = 0;
  endtask

  task automatic test_restart_ignored();
    int len;
    a_matrix = pack2(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000);
    run_job(3*N*N + 1, 5, 0, len);
  endtask

  task automatic test_reset_mid_job();
    int   k;
    int   len;
    logic hit;
    a_matrix = pack2(32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000);
    b_matrix = pack2(ONE, '0, '0, ONE);
    start = 1'b1;
    hit = 1'b0;
    k = 0;
    while (k < 100 && !hit) begin
      @(negedge clk);
      k++;
      start = 1'b0;
      hit = (cur_row == IW'(1) && cur_col == IW'(0) && ip_in_stb);
    end
    checks++;
    if (!hit) $display("[TB] FAIL reach_1_0: got no ISSUE at (1,0) in %0d cycles, required one", k);
    else passes++;
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || ip_in_stb !== 1'b0 || c_matrix !== '0)
      $display("[TB] FAIL mid_reset: got busy=%b stb=%b c=%h required 0/0/0", busy, ip_in_stb, c_matrix);
    else passes++;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    run_job(3*N*N + 1, 0, 0, len);
    checks++;
    if (c_matrix !== a_matrix) $display("[TB] FAIL post_reset_c: got %h required %h", c_matrix, a_matrix);
    else passes++;
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    ack_delay = 0;
    spurious  = 1'b0;
    a_matrix  = '0;
    b_matrix  = '0;
    $display("[TB] starting matrix_mult_scheduler bench, N=%0d", N);
    test_reset();
    test_identity();
    test_select();
    test_ack_delay();
    test_spurious_out_stb();
    test_restart_ignored();
    test_reset_mid_job();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
